// File: rtl/dshot_tx_multi.sv
// Multi-channel DShot frame transmitter: latches one 11-bit value per channel,
// builds the 16-bit packet with checksum and shifts all channels out in lockstep.
module dshot_tx_multi #(
  parameter int NUM_CH = 4,
  parameter int T_BIT  = 40,
  parameter int T1H    = 30,
  parameter int T0H    = 15,
  parameter int GAP    = 80,
  parameter int CNT_W  = 8
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic [11*NUM_CH-1:0]  throttle_in,
  input  logic [NUM_CH-1:0]     telem_req,
  input  logic                  start,
  output logic                  ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [NUM_CH-1:0]     dshot_out
);

  localparam int GAP_W = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] T1H_C     = CNT_W'(T1H);
  localparam logic [CNT_W-1:0] T0H_C     = CNT_W'(T0H);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP - 1);

  if (!((T0H > 0) && (T0H < T1H) && (T1H < T_BIT) && (GAP >= 1) && ((2 ** CNT_W) > T_BIT)))
  begin : g_param_check
    $error("dshot_tx_multi: illegal timing parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Packet = {value, telem, XOR of the three nibbles of that 12-bit word}.
  function automatic logic [15:0] build_pkt(input logic [10:0] value, input logic telem);
    logic [11:0] d12;
    d12 = {value, telem};
    return {d12, d12[11:8] ^ d12[7:4] ^ d12[3:0]};
  endfunction

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_tick;
  logic [CNT_W-1:0]   w_tick_nxt;
  logic [3:0]         r_bit_idx;
  logic [3:0]         w_idx_nxt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic               w_accept;
  logic               w_bit_end;
  logic [15:0]        r_pkt     [NUM_CH];
  logic [15:0]        w_pkt_nxt [NUM_CH];
  logic [NUM_CH-1:0]  r_dshot;
  logic [NUM_CH-1:0]  w_out_nxt;
  logic               r_frame_done;

  assign w_bit_end  = (r_tick == TICK_LAST);
  assign ready      = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign dshot_out  = r_dshot;

  // State register.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and next counter values.
  always_comb begin
    w_next_state = r_state;
    w_tick_nxt   = '0;
    w_idx_nxt    = '0;
    w_gap_nxt    = '0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_SEND;
          w_accept     = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SEND: begin
        if (w_bit_end) begin
          w_idx_nxt = r_bit_idx + 4'd1;
          if (r_bit_idx == 4'd15) begin
            w_next_state = S_GAP;
          end else begin
            w_next_state = S_SEND;
          end
        end else begin
          w_tick_nxt   = r_tick + CNT_W'(1);
          w_idx_nxt    = r_bit_idx;
          w_next_state = S_SEND;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_next_state = S_IDLE;
        end else begin
          w_gap_nxt    = r_gap_cnt + GAP_W'(1);
          w_next_state = S_GAP;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Packet shift registers (current bit always at [15]) and the next line level,
  // computed from next-cycle values so the registered output lines up with the bit.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_accept) begin
        w_pkt_nxt[c] = build_pkt(throttle_in[11*c +: 11], telem_req[c]);
      end else if ((r_state == S_SEND) && w_bit_end) begin
        w_pkt_nxt[c] = {r_pkt[c][14:0], 1'b0};
      end else begin
        w_pkt_nxt[c] = r_pkt[c];
      end
      if (w_next_state == S_SEND) begin
        w_out_nxt[c] = (w_tick_nxt < (w_pkt_nxt[c][15] ? T1H_C : T0H_C));
      end else begin
        w_out_nxt[c] = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_tick       <= '0;
      r_bit_idx    <= '0;
      r_gap_cnt    <= '0;
      r_dshot      <= '0;
      r_frame_done <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_pkt[c] <= 16'h0000;
      end
    end else begin
      r_tick       <= w_tick_nxt;
      r_bit_idx    <= w_idx_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_dshot      <= w_out_nxt;
      r_frame_done <= (r_state == S_GAP) && (r_gap_cnt == GAP_LAST);
      for (int c = 0; c < NUM_CH; c++) begin
        r_pkt[c] <= w_pkt_nxt[c];
      end
    end
  end

endmodule
